// File: rtl/cp0_reg_if.sv
// MTC0/MFC0 access, exception-stage inputs and register-view outputs of the CP0 block.
// The master drives the request side and the slave (cp0_reg) drives the register views.
interface cp0_reg_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic [31:0] exception_type_i;
  logic [31:0] current_pc_i;
  logic        is_in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] badvaddr_o;
  logic        timer_int_o;
  logic [31:0] exc_pc_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i, int_i, exception_type_i, current_pc_i,
           is_in_delayslot_i, bad_addr_i,
    input  rdata_o, status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o, timer_int_o,
           exc_pc_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i, int_i, exception_type_i, current_pc_i,
           is_in_delayslot_i, bad_addr_i,
    output rdata_o, status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o, timer_int_o,
           exc_pc_o
  );
endinterface

// File: rtl/cp0_reg.sv
// MIPS-style coprocessor 0: Status/Cause/EPC/Count/Compare/BadVAddr, timer interrupt,
// exception entry/ERET bookkeeping and the pipeline redirect target.
module cp0_reg #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input logic       clk_i,
  input logic       rst_i,
  cp0_reg_if.slave  bus
);

  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegStatus   = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;

  logic        tick_q, tick_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_q, timer_d;
  logic [7:0]  status_im_q, status_im_d;
  logic        status_exl_q, status_exl_d;
  logic        status_ie_q, status_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_hw_q, cause_hw_d;
  logic [1:0]  cause_sw_q, cause_sw_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic        exc_valid;
  logic        exc_addr;
  logic        eret;
  logic [4:0]  exc_code;

  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [31:0] status_val, cause_val;

  // Decode the exception-stage code; anything unlisted is treated as no event.
  always_comb begin
    exc_valid = 1'b0;
    exc_addr  = 1'b0;
    eret      = 1'b0;
    exc_code  = 5'd0;
    case (bus.exception_type_i)
      32'h0000_0001: begin
        exc_valid = 1'b1;
        exc_code  = 5'd0;
      end
      32'h0000_0004, 32'h0000_0005: begin
        exc_valid = 1'b1;
        exc_addr  = 1'b1;
        exc_code  = bus.exception_type_i[4:0];
      end
      32'h0000_0008, 32'h0000_0009, 32'h0000_000A, 32'h0000_000C, 32'h0000_000D: begin
        exc_valid = 1'b1;
        exc_code  = bus.exception_type_i[4:0];
      end
      32'h0000_000E: eret = 1'b1;
      default: ;
    endcase
  end

  assign wr_count   = bus.we_i && (bus.waddr_i == RegCount);
  assign wr_compare = bus.we_i && (bus.waddr_i == RegCompare);
  assign wr_status  = bus.we_i && (bus.waddr_i == RegStatus);
  assign wr_cause   = bus.we_i && (bus.waddr_i == RegCause);
  assign wr_epc     = bus.we_i && (bus.waddr_i == RegEpc);

  always_comb begin
    tick_d       = ~tick_q;
    count_d      = tick_q ? (count_q + 32'd1) : count_q;
    compare_d    = compare_q;
    timer_d      = timer_q;
    status_im_d  = status_im_q;
    status_exl_d = status_exl_q;
    status_ie_d  = status_ie_q;
    cause_bd_d   = cause_bd_q;
    cause_hw_d   = {bus.int_i[5] | timer_q, bus.int_i[4:0]};
    cause_sw_d   = cause_sw_q;
    cause_exc_d  = cause_exc_q;
    epc_d        = epc_q;
    badvaddr_d   = badvaddr_q;

    // Count and Compare writes are never blocked by an exception or ERET.
    if (wr_count) begin
      count_d = bus.wdata_i;
      tick_d  = 1'b0;
    end
    if (wr_compare) begin
      compare_d = bus.wdata_i;
      timer_d   = 1'b0;
    end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      timer_d = 1'b1;
    end

    if (exc_valid) begin
      // A nested exception keeps the original return address and BD flag.
      if (!status_exl_q) begin
        epc_d      = bus.is_in_delayslot_i ? (bus.current_pc_i - 32'd4) : bus.current_pc_i;
        cause_bd_d = bus.is_in_delayslot_i;
      end
      status_exl_d = 1'b1;
      cause_exc_d  = exc_code;
      if (exc_addr) begin
        badvaddr_d = bus.bad_addr_i;
      end
    end else if (eret) begin
      status_exl_d = 1'b0;
    end else begin
      if (wr_status) begin
        status_im_d  = bus.wdata_i[15:8];
        status_exl_d = bus.wdata_i[1];
        status_ie_d  = bus.wdata_i[0];
      end
      if (wr_cause) begin
        cause_sw_d = bus.wdata_i[9:8];
      end
      if (wr_epc) begin
        epc_d = bus.wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_q       <= 1'b0;
      count_q      <= 32'd0;
      compare_q    <= 32'd0;
      timer_q      <= 1'b0;
      status_im_q  <= 8'd0;
      status_exl_q <= 1'b0;
      status_ie_q  <= 1'b0;
      cause_bd_q   <= 1'b0;
      cause_hw_q   <= 6'd0;
      cause_sw_q   <= 2'd0;
      cause_exc_q  <= 5'd0;
      epc_q        <= 32'd0;
      badvaddr_q   <= 32'd0;
    end else begin
      tick_q       <= tick_d;
      count_q      <= count_d;
      compare_q    <= compare_d;
      timer_q      <= timer_d;
      status_im_q  <= status_im_d;
      status_exl_q <= status_exl_d;
      status_ie_q  <= status_ie_d;
      cause_bd_q   <= cause_bd_d;
      cause_hw_q   <= cause_hw_d;
      cause_sw_q   <= cause_sw_d;
      cause_exc_q  <= cause_exc_d;
      epc_q        <= epc_d;
      badvaddr_q   <= badvaddr_d;
    end
  end

  // BEV (bit 22) is hardwired to 1; all other unlisted bits read as 0.
  assign status_val = {9'd0, 1'b1, 6'd0, status_im_q, 6'd0, status_exl_q, status_ie_q};
  assign cause_val  = {cause_bd_q, 15'd0, cause_hw_q, cause_sw_q, 1'b0, cause_exc_q, 2'b00};

  always_comb begin
    bus.rdata_o = 32'd0;
    case (bus.raddr_i)
      RegBadVAddr: bus.rdata_o = badvaddr_q;
      RegCount:    bus.rdata_o = count_q;
      RegCompare:  bus.rdata_o = compare_q;
      RegStatus:   bus.rdata_o = status_val;
      RegCause:    bus.rdata_o = cause_val;
      RegEpc:      bus.rdata_o = epc_q;
      default:     bus.rdata_o = 32'd0;
    endcase
  end

  // ERET returns through an EPC value being written in the same cycle.
  always_comb begin
    bus.exc_pc_o = 32'd0;
    if (eret) begin
      bus.exc_pc_o = wr_epc ? bus.wdata_i : epc_q;
    end else if (exc_valid) begin
      bus.exc_pc_o = EXC_VECTOR;
    end
  end

  assign bus.status_o    = status_val;
  assign bus.cause_o     = cause_val;
  assign bus.epc_o       = epc_q;
  assign bus.count_o     = count_q;
  assign bus.compare_o   = compare_q;
  assign bus.badvaddr_o  = badvaddr_q;
  assign bus.timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: a table of single-cycle MTC0/exception vectors followed by
// hand-written timer, reset, Count-wrap and interrupt-line sequences.
module tb_cp0_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cp0_reg_if bus_if ();

  cp0_reg #(
    .EXC_VECTOR(32'hBFC0_0380)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus_if)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exc;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [31:0] exp_excpc;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NumVec = 19;
  vec_t vecs [NumVec];

  function automatic vec_t mk(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                              input logic [4:0] raddr, input logic [31:0] exc,
                              input logic [31:0] pc, input logic ds, input logic [31:0] bad,
                              input logic [31:0] exp_excpc, input logic [31:0] exp_rdata);
    vec_t v;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.raddr = raddr; v.exc = exc;
    v.pc = pc; v.ds = ds; v.bad = bad; v.exp_excpc = exp_excpc; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic [31:0] exc, input logic [31:0] pc, input logic ds,
                       input logic [31:0] bad, input logic [5:0] intr);
    bus_if.we_i              = we;
    bus_if.waddr_i           = waddr;
    bus_if.wdata_i           = wdata;
    bus_if.exception_type_i  = exc;
    bus_if.current_pc_i      = pc;
    bus_if.is_in_delayslot_i = ds;
    bus_if.bad_addr_i        = bad;
    bus_if.int_i             = intr;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_status"}, bus_if.status_o, 32'h0040_0000);
    chk({tag, "_cause"}, bus_if.cause_o, 32'd0);
    chk({tag, "_epc"}, bus_if.epc_o, 32'd0);
    chk({tag, "_count"}, bus_if.count_o, 32'd0);
    chk({tag, "_compare"}, bus_if.compare_o, 32'd0);
    chk({tag, "_badvaddr"}, bus_if.badvaddr_o, 32'd0);
    chk({tag, "_timer"}, {31'd0, bus_if.timer_int_o}, 32'd0);
  endtask

  logic found;

  initial begin
    idle();
    bus_if.raddr_i = 5'd0;

    vecs[0]  = mk(1, 5'd12, 32'hFFFF_FF01, 5'd12, 32'h0, 32'h0, 0, 32'h0,
                  32'h0, 32'h0040_FF01);
    vecs[1]  = mk(1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0, 32'h0, 0, 32'h0,
                  32'h0, 32'h0000_0300);
    vecs[2]  = mk(1, 5'd8,  32'h0000_1234, 5'd8,  32'h0, 32'h0, 0, 32'h0,
                  32'h0, 32'h0000_0000);
    vecs[3]  = mk(1, 5'd14, 32'h8000_0ABC, 5'd14, 32'h0, 32'h0, 0, 32'h0,
                  32'h0, 32'h8000_0ABC);
    vecs[4]  = mk(1, 5'd3,  32'hFFFF_FFFF, 5'd3,  32'h0, 32'h0, 0, 32'h0,
                  32'h0, 32'h0000_0000);
    vecs[5]  = mk(0, 5'd0,  32'h0, 5'd14, 32'h4, 32'h8000_1004, 1, 32'h0000_0003,
                  32'hBFC0_0380, 32'h8000_1000);
    vecs[6]  = mk(0, 5'd0,  32'h0, 5'd13, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h8000_0310);
    vecs[7]  = mk(0, 5'd0,  32'h0, 5'd8,  32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0000_0003);
    vecs[8]  = mk(0, 5'd0,  32'h0, 5'd12, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0040_FF03);
    vecs[9]  = mk(0, 5'd0,  32'h0, 5'd14, 32'h8, 32'h8000_2000, 0, 32'h0,
                  32'hBFC0_0380, 32'h8000_1000);
    vecs[10] = mk(0, 5'd0,  32'h0, 5'd13, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h8000_0320);
    vecs[11] = mk(1, 5'd14, 32'h8000_3000, 5'd14, 32'hE, 32'h0, 0, 32'h0,
                  32'h8000_3000, 32'h8000_1000);
    vecs[12] = mk(0, 5'd0,  32'h0, 5'd12, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0040_FF01);
    vecs[13] = mk(1, 5'd12, 32'h0, 5'd12, 32'h1, 32'h8000_4000, 0, 32'h0,
                  32'hBFC0_0380, 32'h0040_FF03);
    vecs[14] = mk(0, 5'd0,  32'h0, 5'd14, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h8000_4000);
    vecs[15] = mk(0, 5'd0,  32'h0, 5'd13, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0000_0300);
    vecs[16] = mk(0, 5'd0,  32'h0, 5'd14, 32'h2, 32'h9000_0000, 1, 32'h0,
                  32'h0, 32'h8000_4000);
    vecs[17] = mk(0, 5'd0,  32'h0, 5'd8,  32'h5, 32'h9000_0000, 1, 32'hDEAD_BEEF,
                  32'hBFC0_0380, 32'hDEAD_BEEF);
    vecs[18] = mk(1, 5'd13, 32'h0, 5'd13, 32'hE, 32'h0, 0, 32'h0,
                  32'h8000_4000, 32'h0000_0314);

    #1;
    check_reset("rst0");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].exc, vecs[i].pc, vecs[i].ds,
            vecs[i].bad, 6'd0);
      bus_if.raddr_i = vecs[i].raddr;
      #1;
      chk($sformatf("vec%0d_excpc", i), bus_if.exc_pc_o, vecs[i].exp_excpc);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rdata", i), bus_if.rdata_o, vecs[i].exp_rdata);
    end

    // Build up mid-operation state: timer pending and EXL set.
    @(negedge clk);
    drive(1'b1, 5'd9, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0);
    @(negedge clk);
    drive(1'b1, 5'd11, 32'd1, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0);
    @(negedge clk);
    idle();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.timer_int_o) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("pre_rst_timer_wait", {31'd0, found}, 32'd1);
    drive(1'b0, 5'd0, 32'd0, 32'h4, 32'h8000_5000, 1'b0, 32'h10, 6'd0);
    @(negedge clk);
    idle();
    chk("pre_rst_exl", {31'd0, bus_if.status_o[1]}, 32'd1);

    #2;
    rst = 1'b1;
    #1;
    check_reset("rst_mid");
    @(posedge clk);
    #1;
    check_reset("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_count_e1", bus_if.count_o, 32'd0);
    chk("post_rst_status", bus_if.status_o, 32'h0040_0000);
    @(negedge clk);
    chk("post_rst_count_e2", bus_if.count_o, 32'd1);

    // Timer: Compare=5, pending one edge after Count reaches 5.
    drive(1'b1, 5'd11, 32'd5, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0);
    @(negedge clk);
    idle();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.count_o == 32'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("wait_count5", {31'd0, found}, 32'd1);
    chk("timer_at_match", {31'd0, bus_if.timer_int_o}, 32'd0);
    @(negedge clk);
    chk("timer_set", {31'd0, bus_if.timer_int_o}, 32'd1);
    @(negedge clk);
    chk("cause15_timer", {31'd0, bus_if.cause_o[15]}, 32'd1);
    repeat (4) @(negedge clk);
    chk("timer_sticky", {31'd0, bus_if.timer_int_o}, 32'd1);
    drive(1'b1, 5'd11, 32'd20, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0);
    @(negedge clk);
    idle();
    chk("timer_clr_by_compare", {31'd0, bus_if.timer_int_o}, 32'd0);
    chk("compare_20", bus_if.compare_o, 32'd20);

    // Compare write coinciding with a match: the write wins for that edge.
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (bus_if.count_o == 32'd20) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("wait_count20", {31'd0, found}, 32'd1);
    drive(1'b1, 5'd11, 32'd20, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0);
    @(negedge clk);
    idle();
    chk("timer_write_wins", {31'd0, bus_if.timer_int_o}, 32'd0);
    @(negedge clk);
    chk("timer_set_after_write", {31'd0, bus_if.timer_int_o}, 32'd1);

    // Count wrap.
    drive(1'b1, 5'd9, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0);
    @(negedge clk);
    idle();
    chk("count_loaded", bus_if.count_o, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("count_hold_tick", bus_if.count_o, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("count_wrap", bus_if.count_o, 32'd0);

    // Hardware interrupt line 0 into Cause[10], immune to MTC0.
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 6'b000001);
    @(negedge clk);
    chk("cause10_set", {29'd0, bus_if.cause_o[10:8]}, 32'd4);
    drive(1'b1, 5'd13, 32'h0000_FB00, 32'd0, 32'd0, 1'b0, 32'd0, 6'b000001);
    @(negedge clk);
    chk("cause10_mtc0", {29'd0, bus_if.cause_o[10:8]}, 32'd7);
    idle();
    @(negedge clk);
    chk("cause10_clear", {29'd0, bus_if.cause_o[10:8]}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_reg.md
CP0_REG -- requirements
Module: cp0_reg

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC0_0380, meaning the exception entry address.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports, one per line: name  direction  width  meaning.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- we_i  in  1  MTC0 write enable.
- waddr_i  in  5  MTC0 register number.
- wdata_i  in  32  MTC0 data.
- raddr_i  in  5  MFC0 register number.
- rdata_o  out  32  MFC0 data.
- int_i  in  6  hardware interrupt lines.
- exception_type_i  in  32  encoded code from the exception stage (0 = none).
- current_pc_i  in  32  PC of the excepting instruction.
- is_in_delayslot_i  in  1  excepting instruction is in a delay slot.
- bad_addr_i  in  32  faulting address for codes 4 and 5.
- status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o  out  32 each  register values.
- timer_int_o  out  1  timer interrupt pending.
- exc_pc_o  out  32  redirect target.

Function
REQ-004 Implemented registers: BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14.
REQ-005 rdata_o SHALL be combinational from raddr_i and reflect current register contents; unimplemented numbers SHALL read 0.
REQ-006 A MTC0 write SHALL take effect at the next rising edge.
- Status writes only bits [15:8] and [1:0].
- Cause writes only bits [9:8].
- Count, Compare and EPC take all 32 bits.
- BadVAddr is read-only.
REQ-007 Count SHALL increment by 1 every second cycle using an internal 1-bit tick toggle, and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-008 A write to Count SHALL load wdata_i and clear the tick.
REQ-009 Timer:
- timer_int_o SHALL set on the edge after Count==Compare with Compare!=0.
- It SHALL stay set until a Compare write, which clears it.
- If a Compare write and the match occur together, the write wins and timer_int_o is 0.
REQ-010 Cause[15:10] SHALL load {int_i[5] | timer_int_o, int_i[4:0]} every cycle and SHALL not be software-writable.
REQ-011 Code map for exception_type_i: 1→ExcCode 0; 4,5,8,9,A,C,D→same value; E=ERET; any other nonzero value SHALL be ignored.
REQ-012 For an exception code other than E, at the edge:
- If Status.EXL=0: EPC = current_pc_i − 4 when is_in_delayslot_i=1, else current_pc_i; Cause[31] (BD) = is_in_delayslot_i.
- If Status.EXL=1: EPC and BD SHALL hold.
- In all cases: Status.EXL=1 and Cause[6:2]=ExcCode.
REQ-013 Codes 4 and 5 SHALL also load BadVAddr=bad_addr_i.
REQ-014 ERET (code E) SHALL clear Status.EXL at the edge.
REQ-015 An exception or ERET SHALL override a same-cycle MTC0 write to Status, Cause, EPC or BadVAddr. A same-cycle MTC0 write to Count or Compare SHALL still take effect.
REQ-016 exc_pc_o SHALL be combinational:
- ERET: epc_o, bypassed to wdata_i when we_i=1 and waddr_i=14 in the same cycle.
- Any other valid code: EXC_VECTOR.
- Otherwise: 0.
REQ-017 Status[31:16] other than bit 22 (BEV) SHALL read 0. Cause bits not listed above SHALL read 0.

Reset
REQ-018 While rst_i=1, outputs SHALL be asynchronously forced to:
- status_o = 32'h0040_0000.
- cause_o, epc_o, count_o, compare_o, badvaddr_o = 0.
- timer_int_o = 0; tick = 0.
REQ-019 Reset asserted mid-operation (EXL=1, timer pending) SHALL discard all state. The first Count increment SHALL occur on the second edge after deassertion.

Verification
REQ-020 Write Compare=5 after reset, idle → timer_int_o=1 one edge after Count reaches 5, Cause[15]=1. Then write Compare=20 → timer_int_o=0 next cycle.
REQ-021 exception_type_i=4, current_pc_i=32'h8000_1004, is_in_delayslot_i=1, bad_addr_i=32'h0000_0003 → EPC=32'h8000_1000, Cause[31]=1, Cause[6:2]=4, BadVAddr=3, EXL=1, exc_pc_o=32'hBFC0_0380.
REQ-022 With EXL=1, apply code 8 at PC 32'h8000_2000 → EPC unchanged, Cause[6:2]=8.
REQ-023 MTC0 EPC=32'h8000_3000 and ERET in the same cycle → exc_pc_o=32'h8000_3000, EXL=0 next edge. Same-cycle exception with an MTC0 Status=0 → EXL=1.
REQ-024 Write Count=32'hFFFF_FFFF → after two cycles Count=0. int_i=6'b000001 → Cause[10]=1 next edge, and Cause[10] is unaffected by MTC0 to Cause.
